// File: rtl/acc_bus_sequencer.sv
// Fetch/decode/execute microsequencer for the 8-bit accumulator machine.
// Decodes the current T-state and opcode into bus strobes, so only one driver is active per cycle.
module acc_bus_sequencer #(
  parameter int unsigned     OPW    = 4,
  parameter logic [OPW-1:0]  HLT_OP = 4'hF
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           run,
  input  logic           prog,
  input  logic [OPW-1:0] opcode,
  input  logic           zero_flag,
  output logic           pc_oe,
  output logic           pc_we,
  output logic           pc_inc,
  output logic           mar_we,
  output logic           mem_oe,
  output logic           mem_we,
  output logic           ir_we,
  output logic           ir_oe,
  output logic           acc_oe,
  output logic           acc_we,
  output logic           b_we,
  output logic           alu_oe,
  output logic           alu_sub,
  output logic           flags_we,
  output logic           out_we,
  output logic           halted,
  output logic           busy,
  output logic [2:0]     tstate
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StF0   = 3'd1,
    StF1   = 3'd2,
    StDec  = 3'd3,
    StE1   = 3'd4,
    StE2   = 3'd5,
    StE3   = 3'd6,
    StHalt = 3'd7
  } state_e;

  localparam logic [OPW-1:0] OpLda = OPW'(1);
  localparam logic [OPW-1:0] OpSta = OPW'(2);
  localparam logic [OPW-1:0] OpAdd = OPW'(3);
  localparam logic [OPW-1:0] OpSub = OPW'(4);
  localparam logic [OPW-1:0] OpJmp = OPW'(5);
  localparam logic [OPW-1:0] OpJz  = OPW'(6);
  localparam logic [OPW-1:0] OpOut = OPW'(7);

  state_e     state_q, state_d;
  state_e     boundary_next;
  logic [1:0] exec_steps;

  // Number of execute steps; the last one is the instruction boundary.
  always_comb begin
    exec_steps = 2'd1;
    if (opcode == OpLda || opcode == OpSta) begin
      exec_steps = 2'd2;
    end else if (opcode == OpAdd || opcode == OpSub) begin
      exec_steps = 2'd3;
    end
  end

  assign boundary_next = (run && !prog) ? StF0 : StIdle;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = boundary_next;
      StF0:    state_d = StF1;
      StF1:    state_d = StDec;
      StDec:   state_d = (opcode == HLT_OP) ? StHalt : StE1;
      StE1:    state_d = (exec_steps == 2'd1) ? boundary_next : StE2;
      StE2:    state_d = (exec_steps == 2'd2) ? boundary_next : StE3;
      StE3:    state_d = boundary_next;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_oe    = 1'b0;
    pc_we    = 1'b0;
    pc_inc   = 1'b0;
    mar_we   = 1'b0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    ir_we    = 1'b0;
    ir_oe    = 1'b0;
    acc_oe   = 1'b0;
    acc_we   = 1'b0;
    b_we     = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    flags_we = 1'b0;
    out_we   = 1'b0;
    unique case (state_q)
      StF0: begin
        pc_oe  = 1'b1;
        mar_we = 1'b1;
      end
      StF1: begin
        mem_oe = 1'b1;
        ir_we  = 1'b1;
        pc_inc = 1'b1;
      end
      StE1: begin
        case (opcode)
          OpLda, OpSta, OpAdd, OpSub: begin
            ir_oe  = 1'b1;
            mar_we = 1'b1;
          end
          OpJmp: begin
            ir_oe = 1'b1;
            pc_we = 1'b1;
          end
          OpJz: begin
            ir_oe = zero_flag;
            pc_we = zero_flag;
          end
          OpOut: begin
            acc_oe = 1'b1;
            out_we = 1'b1;
          end
          default: ;
        endcase
      end
      StE2: begin
        case (opcode)
          OpLda: begin
            mem_oe = 1'b1;
            acc_we = 1'b1;
          end
          OpSta: begin
            acc_oe = 1'b1;
            mem_we = 1'b1;
          end
          OpAdd, OpSub: begin
            mem_oe = 1'b1;
            b_we   = 1'b1;
          end
          default: ;
        endcase
      end
      StE3: begin
        if (opcode == OpAdd || opcode == OpSub) begin
          alu_oe   = 1'b1;
          acc_we   = 1'b1;
          flags_we = 1'b1;
          alu_sub  = (opcode == OpSub);
        end
      end
      default: ;
    endcase
  end

  assign halted = (state_q == StHalt);
  assign busy   = (state_q != StIdle) && (state_q != StHalt);
  assign tstate = state_q;

endmodule

// File: tb/tb_acc_bus_sequencer.sv
// Randomized self-checking bench for acc_bus_sequencer against an instruction-level reference model.
module tb_acc_bus_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, run, prog, zero_flag;
  logic [3:0] opcode;
  logic pc_oe, pc_we, pc_inc, mar_we, mem_oe, mem_we, ir_we, ir_oe;
  logic acc_oe, acc_we, b_we, alu_oe, alu_sub, flags_we, out_we, halted, busy;
  logic [2:0] tstate;

  int tests = 0;
  int fails = 0;

  localparam logic [14:0] PC_OE = 15'h4000, PC_WE = 15'h2000, PC_INC = 15'h1000;
  localparam logic [14:0] MAR_WE = 15'h0800, MEM_OE = 15'h0400, MEM_WE = 15'h0200;
  localparam logic [14:0] IR_WE = 15'h0100, IR_OE = 15'h0080, ACC_OE = 15'h0040;
  localparam logic [14:0] ACC_WE = 15'h0020, B_WE = 15'h0010, ALU_OE = 15'h0008;
  localparam logic [14:0] ALU_SUB = 15'h0004, FLAGS_WE = 15'h0002, OUT_WE = 15'h0001;

  acc_bus_sequencer #(.OPW(4), .HLT_OP(4'hF)) dut (
    .CLK(CLK), .RESET(RESET), .run(run), .prog(prog), .opcode(opcode), .zero_flag(zero_flag),
    .pc_oe(pc_oe), .pc_we(pc_we), .pc_inc(pc_inc), .mar_we(mar_we), .mem_oe(mem_oe),
    .mem_we(mem_we), .ir_we(ir_we), .ir_oe(ir_oe), .acc_oe(acc_oe), .acc_we(acc_we),
    .b_we(b_we), .alu_oe(alu_oe), .alu_sub(alu_sub), .flags_we(flags_we), .out_we(out_we),
    .halted(halted), .busy(busy), .tstate(tstate)
  );

  always #5 CLK = ~CLK;

  function automatic logic [14:0] strobes();
    return {pc_oe, pc_we, pc_inc, mar_we, mem_oe, mem_we, ir_we, ir_oe, acc_oe, acc_we, b_we,
            alu_oe, alu_sub, flags_we, out_we};
  endfunction

  // Reference: instruction length from F0 through the last execute step.
  function automatic int instr_len(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd3 || op == 4'd4) return 6;
    return 4;
  endfunction

  // Reference: strobes of cycle i (0 = F0) of an instruction.
  function automatic logic [14:0] ref_strobes(input logic [3:0] op, input int i, input logic zf);
    case (i)
      0: return PC_OE | MAR_WE;
      1: return MEM_OE | IR_WE | PC_INC;
      2: return '0;
      default: ;
    endcase
    case (op)
      4'd1: return (i == 3) ? (IR_OE | MAR_WE) : (MEM_OE | ACC_WE);
      4'd2: return (i == 3) ? (IR_OE | MAR_WE) : (ACC_OE | MEM_WE);
      4'd3, 4'd4: begin
        if (i == 3) return IR_OE | MAR_WE;
        if (i == 4) return MEM_OE | B_WE;
        return ALU_OE | ACC_WE | FLAGS_WE | ((op == 4'd4) ? ALU_SUB : 15'h0);
      end
      4'd5: return IR_OE | PC_WE;
      4'd6: return zf ? (IR_OE | PC_WE) : 15'h0;
      4'd7: return ACC_OE | OUT_WE;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entry: #1 after the edge that entered F0. prog_at/run_rand perturb inputs mid-instruction.
  task automatic do_instr(input logic [3:0] op, input logic zf, input int prog_at,
                          input bit run_rand, input string name);
    int n;
    logic [14:0] s, e, drv;
    n = instr_len(op);
    opcode = op;
    zero_flag = zf;
    for (int i = 0; i < n; i++) begin
      s = strobes();
      e = ref_strobes(op, i, zf);
      tests++;
      if (tstate !== 3'(i + 1) || s !== e || busy !== 1'b1 || halted !== 1'b0) begin
        fails++;
        $display("FAIL %s op=%0d cyc=%0d: tstate=%0d strobes=%h busy=%b, need %0d %h 1",
                 name, op, i, tstate, s, busy, i + 1, e);
      end
      drv = s & (PC_OE | MEM_OE | IR_OE | ACC_OE | ALU_OE);
      tests++;
      if ($countones(drv) > 1 || (pc_inc && pc_we)) begin
        fails++;
        $display("FAIL %s bus_excl cyc=%0d: drivers=%h pc_inc=%b pc_we=%b, need <=1 driver",
                 name, i, drv, pc_inc, pc_we);
      end
      if (i == prog_at) prog = 1'b1;
      if (run_rand) run = 1'($urandom_range(0, 1));
      tick();
    end
    tests++;
    if (tstate !== ((run && !prog) ? 3'd1 : 3'd0)) begin
      fails++;
      $display("FAIL %s boundary op=%0d: tstate=%0d, need %0d", name, op, tstate,
               (run && !prog) ? 1 : 0);
    end
  endtask

  task automatic start();
    run = 1'b1;
    prog = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    run = 1'b0; prog = 1'b0; opcode = 4'd0; zero_flag = 1'b0;
    tick();
    tests++;
    if (tstate !== 3'd0 || strobes() !== '0 || halted !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: tstate=%0d strobes=%h halted=%b busy=%b, need 0 0 0 0",
               tstate, strobes(), halted, busy);
    end
    RESET = 1'b0;
    // Reset in the middle of ADD, at E2.
    opcode = 4'd3;
    start();
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (tstate !== 3'd5 || b_we !== 1'b1) begin
      fails++;
      $display("FAIL add_e2: tstate=%0d b_we=%b, need 5 1", tstate, b_we);
    end
    run = 1'b0;
    #2 RESET = 1'b1;
    #1;
    tests++;
    if (tstate !== 3'd0 || b_we !== 1'b0 || strobes() !== '0) begin
      fails++;
      $display("FAIL reset_mid_add: tstate=%0d b_we=%b strobes=%h, need 0 0 0",
               tstate, b_we, strobes());
    end
    #1 RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (tstate !== 3'd0 || strobes() !== '0) begin
        fails++;
        $display("FAIL idle_hold: tstate=%0d strobes=%h, need 0 0", tstate, strobes());
      end
    end
  endtask

  task automatic test_lda();
    start();
    do_instr(4'd1, 1'b0, -1, 1'b0, "lda");
  endtask

  task automatic test_sub();
    do_instr(4'd4, 1'b0, -1, 1'b0, "sub");
  endtask

  task automatic test_jz();
    do_instr(4'd6, 1'b0, -1, 1'b0, "jz_nz");
    do_instr(4'd6, 1'b1, -1, 1'b0, "jz_z");
  endtask

  task automatic test_prog();
    do_instr(4'd3, 1'b1, 3, 1'b0, "prog_add");
    tick();
    tests++;
    if (tstate !== 3'd0 || strobes() !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL prog_idle: tstate=%0d strobes=%h busy=%b, need 0 0 0",
               tstate, strobes(), busy);
    end
    prog = 1'b0;
    tick();
    tests++;
    if (tstate !== 3'd1) begin
      fails++;
      $display("FAIL prog_release: tstate=%0d, need 1", tstate);
    end
  endtask

  task automatic test_halt();
    opcode = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (tstate !== 3'd7 || halted !== 1'b1 || busy !== 1'b0 || strobes() !== '0) begin
        fails++;
        $display("FAIL halt_hold cyc=%0d: tstate=%0d halted=%b busy=%b strobes=%h, need 7 1 0 0",
                 i, tstate, halted, busy, strobes());
      end
      run = 1'($urandom_range(0, 1));
      prog = 1'($urandom_range(0, 1));
      tick();
    end
    RESET = 1'b1;
    #1;
    tests++;
    if (tstate !== 3'd0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_reset: tstate=%0d halted=%b, need 0 0", tstate, halted);
    end
    RESET = 1'b0;
    prog = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] op;
    start();
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 14));
      do_instr(op, 1'($urandom_range(0, 1)), -1, 1'b1, "random");
      if (tstate == 3'd0) start();
      else run = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sub();
    test_jz();
    test_prog();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
